issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/esm_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/issue_scheduler.sv | 104 ++++++++++
 tb/tb_issue_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared issue-scheduler types: slot state encoding, default buffer depth, index-width helper.
package esm_pkg;

  localparam int BS_DEFAULT = 16;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_WAITING = 2'd1,
    SLOT_ISSUED  = 2'd2
  } slot_state_e;

  function automatic int idx_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request bit at or above ptr, wrapping; purely combinational.
module rr_arbiter #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  logic [W-1:0] cand;

  // N is a power of two, so W-bit addition wraps the search for free.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + W'(i);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Dependency-tracking issue buffer: alloc/issue/done each take effect at the next edge;
// issue is held while issue_ready is low, alloc is refused while no slot is FREE.
module issue_scheduler
  import esm_pkg::*;
#(
  parameter  int BS      = BS_DEFAULT,
  localparam int BS_BITS = idx_bits(BS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc_valid,
  input  logic [BS-1:0]      alloc_deps,
  output logic               alloc_ready,
  output logic [BS_BITS-1:0] alloc_idx,
  output logic               issue_valid,
  output logic [BS_BITS-1:0] issue_idx,
  input  logic               issue_ready,
  input  logic               done_valid,
  input  logic [BS_BITS-1:0] done_idx,
  output logic               done_err,
  output logic [BS_BITS:0]   occupancy
);

  slot_state_e        state [BS];
  logic [BS-1:0]      row   [BS];
  logic [BS_BITS-1:0] rr_ptr;

  logic [BS-1:0] free_vec;
  logic [BS-1:0] ready_vec;
  logic [BS-1:0] done_mask;
  logic [BS-1:0] alloc_row;
  logic          alloc_fire;
  logic          issue_fire;
  logic          done_ok;

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int j = 0; j < BS; j++) begin
      free_vec[j]  = (state[j] == SLOT_FREE);
      ready_vec[j] = (state[j] == SLOT_WAITING) && (row[j] == '0);
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int j = BS - 1; j >= 0; j--) begin
      if (free_vec[j]) alloc_idx = BS_BITS'(j);
    end
  end

  assign alloc_ready = !rst && !flush && (|free_vec);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_fire  = issue_valid && issue_ready;
  assign done_ok     = done_valid && (state[done_idx] == SLOT_ISSUED);

  // Producers already FREE (or completing this cycle) can never clear the bit later, so drop them now.
  assign done_mask = done_valid ? (BS'(1) << done_idx) : '0;
  assign alloc_row = alloc_deps & ~free_vec & ~(BS'(1) << alloc_idx) & ~done_mask;

  rr_arbiter #(
    .N (BS),
    .W (BS_BITS)
  ) u_rr_arbiter (
    .req     (ready_vec),
    .ptr     (rr_ptr),
    .gnt_idx (issue_idx),
    .gnt_vld (issue_valid)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int j = 0; j < BS; j++) begin
        state[j] <= SLOT_FREE;
        row[j]   <= '0;
      end
      rr_ptr    <= '0;
      occupancy <= '0;
      done_err  <= 1'b0;
    end else begin
      done_err <= done_valid && !done_ok;
      if (done_ok) begin
        for (int j = 0; j < BS; j++) row[j][done_idx] <= 1'b0;
        state[done_idx] <= SLOT_FREE;
      end
      if (issue_fire) begin
        state[issue_idx] <= SLOT_ISSUED;
        rr_ptr           <= issue_idx + 1'b1;
      end
      // Allocated row already excludes done_idx, so overriding the column clear is safe.
      if (alloc_fire) begin
        state[alloc_idx] <= SLOT_WAITING;
        row[alloc_idx]   <= alloc_row;
      end
      case ({alloc_fire, done_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed scenarios plus random traffic against a slot-list reference model (BS=4).
module tb_issue_scheduler;

  localparam int BS = 4;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       alloc_valid;
  logic [3:0] alloc_deps;
  logic       alloc_ready;
  logic [1:0] alloc_idx;
  logic       issue_valid;
  logic [1:0] issue_idx;
  logic       issue_ready;
  logic       done_valid;
  logic [1:0] done_idx;
  logic       done_err;
  logic [2:0] occupancy;

  issue_scheduler #(.BS(BS)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_deps  (alloc_deps),
    .alloc_ready (alloc_ready),
    .alloc_idx   (alloc_idx),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_ready (issue_ready),
    .done_valid  (done_valid),
    .done_idx    (done_idx),
    .done_err    (done_err),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 FREE, 1 WAITING, 2 ISSUED; waits_on[s] holds the producers s still needs.
  int m_st [BS];
  int waits_on [BS][$];
  int m_ptr;
  int m_err;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int m_occ();
    int c = 0;
    foreach (m_st[s]) if (m_st[s] != 0) c++;
    return c;
  endfunction

  task automatic m_reset();
    foreach (m_st[s]) begin
      m_st[s] = 0;
      waits_on[s].delete();
    end
    m_ptr = 0;
    m_err = 0;
  endtask

  function automatic int m_lowest_free();
    for (int s = 0; s < BS; s++) if (m_st[s] == 0) return s;
    return -1;
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < BS; k++) begin
      int s = (m_ptr + k) % BS;
      if (m_st[s] == 1 && waits_on[s].size() == 0) return s;
    end
    return -1;
  endfunction

  // One clock: drive inputs, compare every output with the model, clock, advance the model.
  task automatic cyc(input bit r, input bit f, input bit a, input logic [3:0] d,
                     input bit ir, input bit dv, input int di);
    int  lf, pk, ai;
    bit  exp_ar, acc, dok;
    rst = r; flush = f; alloc_valid = a; alloc_deps = d;
    issue_ready = ir; done_valid = dv; done_idx = 2'(di);
    #1;
    lf     = m_lowest_free();
    pk     = m_pick();
    ai     = (lf < 0) ? 0 : lf;
    exp_ar = !r && !f && (lf >= 0);
    check("alloc_ready", int'(alloc_ready), int'(exp_ar));
    check("alloc_idx",   int'(alloc_idx),   ai);
    check("issue_valid", int'(issue_valid), int'(pk >= 0));
    if (pk >= 0) check("issue_idx", int'(issue_idx), pk);
    check("occupancy",   int'(occupancy),   m_occ());
    check("done_err",    int'(done_err),    m_err);
    @(posedge clk);
    if (r || f) begin
      m_reset();
    end else begin
      acc   = a && exp_ar;
      dok   = dv && (m_st[di] == 2);
      m_err = (dv && !dok) ? 1 : 0;
      if (ir && pk >= 0) begin
        m_st[pk] = 2;
        m_ptr    = (pk + 1) % BS;
      end
      if (acc) begin
        waits_on[ai].delete();
        for (int p = 0; p < BS; p++)
          if (d[p] && p != ai && m_st[p] != 0 && !(dv && p == di)) waits_on[ai].push_back(p);
      end
      if (dok) begin
        m_st[di] = 0;
        foreach (m_st[s]) begin
          for (int q = waits_on[s].size() - 1; q >= 0; q--)
            if (waits_on[s][q] == di) waits_on[s].delete(q);
        end
      end
      if (acc) m_st[ai] = 1;
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 4'b0000, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_deps = '0;
    issue_ready = 1'b0; done_valid = 1'b0; done_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    rst = 1'b0;
    #1;
    check("rst_issue_valid", int'(issue_valid), 0);
    check("rst_alloc_idx",   int'(alloc_idx),   0);
    check("rst_alloc_ready", int'(alloc_ready), 1);
    check("rst_occupancy",   int'(occupancy),   0);
    check("rst_done_err",    int'(done_err),    0);

    // First alloc, then issue slot 0.
    cyc(0, 0, 1, 4'b0000, 0, 0, 0);
    check("a33_issue_valid", int'(issue_valid), 1);
    check("a33_issue_idx",   int'(issue_idx),   0);
    cyc(0, 0, 0, 4'b0000, 1, 0, 0);

    // Dependent of an ISSUED producer stays blocked until the producer completes.
    cyc(0, 0, 1, 4'b0001, 1, 0, 0);
    check("a34_blocked", int'(issue_valid), 0);
    cyc(0, 0, 0, 4'b0000, 0, 1, 0);
    check("a34_issue_valid", int'(issue_valid), 1);
    check("a34_issue_idx",   int'(issue_idx),   1);
    cyc(0, 0, 0, 4'b0000, 1, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, 1, 1);

    // Fill all slots from a clean pointer, then drain in round-robin order.
    cyc(0, 1, 0, 4'b0000, 0, 0, 0);
    for (int k = 0; k < BS; k++) cyc(0, 0, 1, 4'b0000, 0, 0, 0);
    check("a35_alloc_ready", int'(alloc_ready), 0);
    check("a35_occupancy",   int'(occupancy),   4);
    for (int k = 0; k < BS; k++) begin
      check("a35_issue_order", int'(issue_idx), k);
      cyc(0, 0, 0, 4'b0000, 1, 0, 0);
    end
    for (int k = 0; k < BS; k++) cyc(0, 0, 0, 4'b0000, 0, 1, k);
    check("a35_drained", int'(occupancy), 0);

    // Dependencies on FREE slots are dropped.
    cyc(0, 0, 1, 4'b1110, 0, 0, 0);
    check("a36_issue_valid", int'(issue_valid), 1);
    check("a36_issue_idx",   int'(issue_idx),   0);

    // Completion for a WAITING slot is an error and changes nothing.
    cyc(0, 0, 1, 4'b0000, 0, 0, 0);
    cyc(0, 0, 1, 4'b0000, 0, 0, 0);
    cyc(0, 0, 0, 4'b0000, 0, 1, 2);
    check("a37_done_err",  int'(done_err),  1);
    check("a37_occupancy", int'(occupancy), 3);
    idle();
    check("a37_err_pulse", int'(done_err), 0);

    // Flush beats a concurrent alloc.
    cyc(0, 1, 1, 4'b0000, 0, 0, 0);
    check("a38_occupancy",   int'(occupancy),   0);
    check("a38_issue_valid", int'(issue_valid), 0);
    check("a38_alloc_idx",   int'(alloc_idx),   0);

    // Random traffic; done_idx biased towards ISSUED slots so completions actually happen.
    for (int n = 0; n < 3000; n++) begin
      int di;
      bit r, f;
      di = $urandom_range(0, BS - 1);
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < BS; k++) if (m_st[(di + k) % BS] == 2) begin di = (di + k) % BS; break; end
      end
      r = ($urandom_range(0, 499) == 0);
      f = ($urandom_range(0, 63) == 0);
      cyc(r, f, 1'($urandom_range(0, 1)), 4'($urandom()), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) != 0), di);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
